wb_scoreboard: RTL and testbench

Writeback stage directly upstream of the register file. It merges the single-cycle ALU result stream with the long-latency load/mul-div result stream into the regfile's single write port. It keeps a per-register pending scoreboard for long-latency destinations and drives a RAW/WAW hazard signal to decode for stalls. The block has no forwarding paths, so an in-flight write is treated as a hazard.

---
 rtl/wb_scoreboard.sv | 122 ++++++++++++
 tb/tb_wb_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: writeback stage in front of the register file.
// Merges the single-cycle ALU result stream and the long-latency (load /
// mul-div) result stream into the single regfile write port. It tracks
// destinations of in-flight long-latency ops in a pending scoreboard and
// tells decode to stall on RAW/WAW hazards. There is no forwarding, so a
// write sitting in the output register is also a hazard.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/rd/data        ALU result, no backpressure, always wins
//   ld_valid/ready/rd/data   long-latency result, valid/ready handshake
//   iss_valid/rd             long-latency op issued (sets pending bit)
//   chk_ra1/ra2/rd           decode operands to check for hazards
//   hazard                   decode must stall
//   idle                     nothing pending, no write in flight
//   err                      sticky protocol error
//   rf_we/wa/wd              registered regfile write port
module wb_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   chk_ra1,
    input  logic [AW-1:0]   chk_ra2,
    input  logic [AW-1:0]   chk_rd,
    output logic            hazard,
    output logic            idle,
    output logic            err,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [XLEN-1:0] rf_wd
);

    logic [NREG-1:0] pend_q, pend_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_wa_q, rf_wa_d;
    logic [XLEN-1:0] rf_wd_q, rf_wd_d;
    logic            err_q, err_d;

    logic alu_wr;
    logic ld_acc;
    logic iss_set;

    // An ALU write to x0 is consumed without using the port, so the
    // long-latency stream may go through in that cycle.
    assign alu_wr   = alu_valid && (alu_rd != '0);
    assign ld_ready = !alu_wr;
    assign ld_acc   = ld_valid && ld_ready;
    assign iss_set  = iss_valid && (iss_rd != '0);

    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (alu_wr) begin
            rf_we_d = 1'b1;
            rf_wa_d = alu_rd;
            rf_wd_d = alu_data;
        end else if (ld_acc && (ld_rd != '0)) begin
            rf_we_d = 1'b1;
            rf_wa_d = ld_rd;
            rf_wd_d = ld_data;
        end
    end

    // Clear before set: a completion and a new issue to the same register
    // in one cycle leave it pending for the newer op.
    always_comb begin
        pend_d = pend_q;
        if (ld_acc) pend_d[ld_rd] = 1'b0;
        if (iss_set) pend_d[iss_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // Re-issue to a pending register is legal only when that register
    // completes in the same cycle.
    always_comb begin
        err_d = err_q;
        if (ld_acc && (ld_rd != '0) && !pend_q[ld_rd]) err_d = 1'b1;
        if (iss_set && pend_q[iss_rd] && !(ld_acc && (ld_rd == iss_rd))) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
            err_q   <= err_d;
        end
    end

    function automatic logic src_haz(input logic [AW-1:0] ra);
        return (ra != '0) && (pend_q[ra] || (rf_we_q && (rf_wa_q == ra)));
    endfunction

    assign hazard = src_haz(chk_ra1) || src_haz(chk_ra2) ||
                    ((chk_rd != '0) && pend_q[chk_rd]);
    assign idle   = (pend_q == '0) && !rf_we_q;
    assign err    = err_q;
    assign rf_we  = rf_we_q;
    assign rf_wa  = rf_wa_q;
    assign rf_wd  = rf_wd_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: directed scenarios followed by
// randomized traffic, checked against a rule-level model of the block.
module tb_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid, ld_ready, iss_valid;
    logic [4:0]  alu_rd, ld_rd, iss_rd, chk_ra1, chk_ra2, chk_rd;
    logic [31:0] alu_data, ld_data;
    logic        hazard, idle, err, rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    wb_scoreboard #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_rd(chk_rd),
        .hazard(hazard), .idle(idle), .err(err),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;

    // Reference model state
    logic [31:0] m_pend;
    logic        m_err;
    logic        m_we;
    logic [4:0]  m_wa;
    logic        last_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_src(input logic [4:0] ra);
        return (ra != 0) && (m_pend[ra] || (m_we && m_wa == ra));
    endfunction

    // Monitor: every write the DUT presents must match the oldest expected one,
    // and an expected write must not be missing.
    always @(posedge clk) begin
        #1;
        if (rf_we === 1'b1 || exp_q.size() != 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, rf_wa}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("rf_we", {31'd0, rf_we}, 32'd1);
                check("rf_wa", {27'd0, rf_wa}, {27'd0, e.wa});
                check("rf_wd", rf_wd, e.wd);
            end
        end
    end

    task automatic clr();
        rst = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        iss_valid = 0; iss_rd = 0; chk_ra1 = 0; chk_ra2 = 0; chk_rd = 0;
    endtask

    // Called just after a falling edge with inputs already driven. Checks the
    // combinational outputs against the model, then advances the model and
    // the clock by one cycle.
    task automatic cycle();
        logic alu_w, acc;
        #1;
        alu_w = alu_valid && alu_rd != 0;
        check("ld_ready", {31'd0, ld_ready}, {31'd0, !alu_w});
        check("hazard", {31'd0, hazard},
              {31'd0, m_src(chk_ra1) || m_src(chk_ra2) || (chk_rd != 0 && m_pend[chk_rd])});
        check("idle", {31'd0, idle}, {31'd0, (m_pend == 0) && !m_we});
        check("err", {31'd0, err}, {31'd0, m_err});
        acc = ld_valid && !alu_w;
        last_acc = acc && !rst;
        if (rst) begin
            m_pend = 0; m_err = 0; m_we = 0;
        end else begin
            m_we = 0;
            if (alu_w) begin
                exp_q.push_back('{alu_rd, alu_data});
                m_we = 1; m_wa = alu_rd;
            end else if (acc && ld_rd != 0) begin
                exp_q.push_back('{ld_rd, ld_data});
                m_we = 1; m_wa = ld_rd;
            end
            if (acc && ld_rd != 0 && !m_pend[ld_rd]) m_err = 1;
            if (iss_valid && iss_rd != 0 && m_pend[iss_rd] && !(acc && ld_rd == iss_rd)) m_err = 1;
            if (acc) m_pend[ld_rd] = 0;
            if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
            m_pend[0] = 0;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] rd);
        clr(); iss_valid = 1; iss_rd = rd; cycle(); clr();
    endtask

    int          os_q[$];
    logic        hold;

    initial begin
        clr();
        m_pend = 0; m_err = 0; m_we = 0; m_wa = 0; last_acc = 0;
        // Reset for two cycles with ALU traffic present
        rst = 1; alu_valid = 1; alu_rd = 5; alu_data = 32'h55;
        @(posedge clk); @(negedge clk);
        cycle();
        clr();
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
        check("rst_rf_wd", rf_wd, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_hazard", {31'd0, hazard}, 32'd0);

        // ALU write latency and in-flight hazard
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; cycle();
        clr(); chk_ra1 = 5; #1;
        check("alu_inflight_haz", {31'd0, hazard}, 32'd1);
        cycle(); chk_ra1 = 5; #1;
        check("alu_done_haz", {31'd0, hazard}, 32'd0);
        cycle();

        // Scoreboard RAW / WAW on x7
        issue(7);
        for (int i = 0; i < 3; i++) begin chk_ra2 = 7; cycle(); end
        clr(); chk_rd = 7; #1;
        check("waw_haz", {31'd0, hazard}, 32'd1);
        cycle();
        clr(); chk_ra2 = 7; ld_valid = 1; ld_rd = 7; ld_data = 32'h1234; cycle();
        clr(); chk_ra2 = 7; #1;
        check("ld_inflight_haz", {31'd0, hazard}, 32'd1);
        cycle(); chk_ra2 = 7; cycle();

        // Collision: ALU x3 wins, x7 follows
        issue(7);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h3333;
        ld_valid = 1; ld_rd = 7; ld_data = 32'h7777; #1;
        check("collide_ready", {31'd0, ld_ready}, 32'd0);
        cycle();
        alu_valid = 0; cycle();
        clr(); cycle();

        // x0 handling
        issue(8);
        alu_valid = 1; alu_rd = 0; alu_data = 32'hBAD;
        ld_valid = 1; ld_rd = 8; ld_data = 32'h8888; cycle();
        clr(); iss_valid = 1; iss_rd = 0; cycle();
        clr(); cycle();

        // Same-cycle issue and completion of x4 keeps it pending, no error
        issue(4);
        iss_valid = 1; iss_rd = 4; ld_valid = 1; ld_rd = 4; ld_data = 32'h4444; cycle();
        clr(); chk_rd = 4; #1;
        check("reissue_pend", {31'd0, hazard}, 32'd1);
        check("reissue_err", {31'd0, err}, 32'd0);
        cycle();
        clr(); ld_valid = 1; ld_rd = 4; ld_data = 32'h4445; cycle();

        // Unexpected completion to x9: write happens, err sticks
        clr(); ld_valid = 1; ld_rd = 9; ld_data = 32'h9999; cycle();
        clr(); cycle(); cycle();
        check("err_sticky", {31'd0, err}, 32'd1);
        rst = 1; cycle(); clr(); cycle();

        // Randomized traffic
        os_q = {};
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] r;
            alu_valid = ($urandom_range(0, 2) == 0);
            alu_rd = 5'($urandom_range(0, 31));
            alu_data = $urandom;
            chk_ra1 = 5'($urandom_range(0, 31));
            chk_ra2 = 5'($urandom_range(0, 31));
            chk_rd = 5'($urandom_range(0, 31));
            if (!hold) begin
                ld_valid = 0;
                if (os_q.size() != 0 && $urandom_range(0, 2) == 0) begin
                    ld_valid = 1; ld_rd = 5'(os_q[0]); ld_data = $urandom; hold = 1;
                end else if ($urandom_range(0, 40) == 0) begin
                    ld_valid = 1; ld_rd = 0; ld_data = $urandom; hold = 1;
                end
            end
            iss_valid = 0;
            r = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0 && !m_pend[r]) begin
                iss_valid = 1; iss_rd = r;
            end
            rst = ($urandom_range(0, 199) == 0);
            cycle();
            if (rst) begin
                os_q = {}; hold = 0; ld_valid = 0;
            end else begin
                if (last_acc) begin
                    hold = 0;
                    ld_valid = 0;
                    if (ld_rd != 0) void'(os_q.pop_front());
                end
                if (iss_valid && iss_rd != 0) os_q.push_back(int'(iss_rd));
            end
        end

        clr(); cycle(); cycle();
        check("wr_q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
